// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// The master drives operands and result-ready; the slave (the unit) answers.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic [2:0]       out_op;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_y, out_op
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_y, out_op
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit logic unit (8 ops, 1-cycle latency) with a built-in
// truth-table sweep that self-checks the gate set across all lanes.
//
// state | meaning
// IDLE  | normal operation, operands accepted
// DRAIN | sweep requested, waiting for a pending result to be consumed
// RUN   | applying sweep vector k = 0..31, one per cycle
// DONE  | one-cycle completion pulse, then back to IDLE
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    logic_unit_pipe_if.slave bus,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [31:0]      sweep_tt,
    output logic             sweep_err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, DRAIN, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [4:0]         k_q, k_d;
    logic [31:0]        tt_q, tt_d;
    logic               err_q, err_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_y_q, out_y_d;
    logic [2:0]         out_op_q, out_op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               in_ready;
    logic               accept;
    logic [WIDTH-1:0]   sw_y;

    function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return a ^ b;
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    // in_ready is forced low while reset is asserted so nothing is taken in that cycle
    assign in_ready = !rst && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    // Sweep operands are full-lane replicas of pattern bits, so a healthy result is uniform
    assign sw_y = logic_op(k_q[4:2], {WIDTH{k_q[1]}}, {WIDTH{k_q[0]}});

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        tt_d        = tt_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_op_d    = out_op_q;
        cnt_d       = cnt_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_y_d     = logic_op(bus.in_op, bus.in_a, bus.in_b);
            out_op_d    = bus.in_op;
            cnt_d       = cnt_q + CNT_W'(1);
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (sweep_start) state_d = DRAIN;
            end
            DRAIN: begin
                if (!out_valid_q) begin
                    state_d = RUN;
                    k_d     = 5'd0;
                    tt_d    = 32'd0;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                tt_d[k_q] = sw_y[0];
                if ((sw_y != '0) && (sw_y != '1)) err_d = 1'b1;
                k_d = k_q + 5'd1;
                if (k_q == 5'd31) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= 5'd0;
            tt_q        <= 32'd0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_op_q    <= 3'd0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            tt_q        <= tt_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_op_q    <= out_op_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_op    = out_op_q;
    assign sweep_busy    = (state_q == DRAIN) || (state_q == RUN);
    assign sweep_done    = (state_q == DONE);
    assign sweep_tt      = tt_q;
    assign sweep_err     = err_q;
    assign op_count      = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench: vector table, hand-written sweep/backpressure/reset
// sequences and a random stream checked against a queue reference model.
module tb_logic_unit_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        sweep_start, sweep_start2;
    logic        sweep_busy, sweep_done, sweep_err;
    logic        sweep_busy2, sweep_done2, sweep_err2;
    logic [31:0] sweep_tt, sweep_tt2;
    logic [15:0] op_count;
    logic [3:0]  op_count2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(8)) bus0 ();
    logic_unit_pipe_if #(.WIDTH(1)) bus1 ();

    logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus0), .sweep_start(sweep_start),
        .sweep_busy(sweep_busy), .sweep_done(sweep_done), .sweep_tt(sweep_tt),
        .sweep_err(sweep_err), .op_count(op_count)
    );

    logic_unit_pipe #(.WIDTH(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .sweep_start(sweep_start2),
        .sweep_busy(sweep_busy2), .sweep_done(sweep_done2), .sweep_tt(sweep_tt2),
        .sweep_err(sweep_err2), .op_count(op_count2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bitwise reference: evaluates each lane with boolean operators
    function automatic logic [7:0] ref_op(input int op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) begin
            case (op)
                0: y[i] = a[i] && b[i];
                1: y[i] = a[i] || b[i];
                2: y[i] = !a[i];
                3: y[i] = a[i] != b[i];
                4: y[i] = !(a[i] && b[i]);
                5: y[i] = !(a[i] || b[i]);
                6: y[i] = a[i] == b[i];
                default: y[i] = a[i];
            endcase
        end
        return y;
    endfunction

    function automatic logic [31:0] ref_tt();
        logic [31:0] t;
        logic [7:0]  y;
        for (int k = 0; k < 32; k++) begin
            y = ref_op(k / 4, {8{((k % 4) / 2) == 1}}, {8{(k % 2) == 1}});
            t[k] = y[0];
        end
        return t;
    endfunction

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
    } vec_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] y;
    } res_t;

    // Wait for sweep_done on dut; returns busy cycles seen and whether out_valid rose
    task automatic wait_sweep0(output int busy_n, output bit done_seen, output bit ov_seen);
        busy_n = 0; done_seen = 0; ov_seen = 0;
        for (int c = 0; c < 200 && !done_seen; c++) begin
            if (c > 0) @(negedge clk);
            if (sweep_busy) busy_n++;
            if (bus0.out_valid) ov_seen = 1;
            if (sweep_done) done_seen = 1;
        end
    endtask

    vec_t        tab[8];
    res_t        mq[$];
    res_t        r;
    logic [31:0] exp_tt;
    int          busy_n;
    bit          done_seen, ov_seen;
    int          model_cnt;
    bit          exp_ready;

    initial begin
        exp_tt = ref_tt();
        tab[0] = '{3'd0, 8'hF0, 8'hCC, 8'hC0};
        tab[1] = '{3'd1, 8'hF0, 8'hCC, 8'hFC};
        tab[2] = '{3'd2, 8'hF0, 8'hCC, 8'h0F};
        tab[3] = '{3'd3, 8'hF0, 8'hCC, 8'h3C};
        tab[4] = '{3'd4, 8'hF0, 8'hCC, 8'h3F};
        tab[5] = '{3'd5, 8'hF0, 8'hCC, 8'h03};
        tab[6] = '{3'd6, 8'hF0, 8'hCC, 8'hC3};
        tab[7] = '{3'd7, 8'hF0, 8'hCC, 8'hF0};

        rst = 1'b1;
        sweep_start = 1'b0; sweep_start2 = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_a = '0; bus0.in_b = '0; bus0.in_op = '0; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_op = '0; bus1.out_ready = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("in_ready during reset", bus0.in_ready, 0);
        chk("out_valid reset", bus0.out_valid, 0);
        chk("out_y reset", bus0.out_y, 0);
        chk("out_op reset", bus0.out_op, 0);
        chk("sweep_busy reset", sweep_busy, 0);
        chk("sweep_done reset", sweep_done, 0);
        chk("sweep_tt reset", sweep_tt, 0);
        chk("sweep_err reset", sweep_err, 0);
        chk("op_count reset", op_count, 0);
        rst = 1'b0;
        #1;
        chk("in_ready after reset", bus0.in_ready, 1);

        // table: all ops back-to-back, out_ready held high
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("tab%0d out_valid", i - 1), bus0.out_valid, 1);
                chk($sformatf("tab%0d out_y", i - 1), bus0.out_y, tab[i - 1].y);
                chk($sformatf("tab%0d out_op", i - 1), bus0.out_op, tab[i - 1].op);
            end
            if (i < 8) begin
                bus0.in_valid = 1'b1; bus0.in_op = tab[i].op;
                bus0.in_a = tab[i].a; bus0.in_b = tab[i].b;
            end else begin
                bus0.in_valid = 1'b0;
            end
        end
        chk("op_count after table", op_count, 8);

        // backpressure
        @(negedge clk);
        bus0.out_ready = 1'b0; bus0.in_valid = 1'b1;
        bus0.in_a = 8'hAA; bus0.in_b = 8'h55; bus0.in_op = 3'd3;
        @(negedge clk);
        bus0.in_a = 8'hF0; bus0.in_b = 8'hCC; bus0.in_op = 3'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp out_valid", bus0.out_valid, 1);
            chk("bp out_y", bus0.out_y, 8'hFF);
            chk("bp out_op", bus0.out_op, 3);
            chk("bp in_ready", bus0.in_ready, 0);
            @(negedge clk);
        end
        chk("bp op_count held", op_count, 9);
        bus0.out_ready = 1'b1;
        #1;
        chk("bp in_ready on release", bus0.in_ready, 1);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        chk("bp second out_y", bus0.out_y, 8'hC0);
        chk("bp second out_op", bus0.out_op, 0);
        chk("bp op_count", op_count, 10);
        @(negedge clk);
        chk("bp drained", bus0.out_valid, 0);

        // sweep from idle; operands offered during the sweep must be refused
        sweep_start = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0; bus0.in_valid = 1'b1;
        wait_sweep0(busy_n, done_seen, ov_seen);
        bus0.in_valid = 1'b0;
        chk("sweep1 done seen", done_seen, 1);
        chk("sweep1 busy cycles", busy_n, 33);
        chk("sweep1 out_valid quiet", ov_seen, 0);
        chk("sweep1 tt", sweep_tt, exp_tt);
        chk("sweep1 err", sweep_err, 0);
        chk("sweep1 op_count", op_count, 10);
        @(negedge clk);
        chk("sweep1 done one cycle", sweep_done, 0);
        chk("sweep1 tt hold", sweep_tt, exp_tt);

        // sweep with pending result and out_ready low
        bus0.out_ready = 1'b0; bus0.in_valid = 1'b1;
        bus0.in_a = 8'h5A; bus0.in_op = 3'd7; sweep_start = 1'b1;
        @(negedge clk);
        bus0.in_valid = 1'b0; sweep_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain busy", sweep_busy, 1);
            chk("drain in_ready", bus0.in_ready, 0);
            chk("drain pending y", bus0.out_y, 8'h5A);
            @(negedge clk);
        end
        bus0.out_ready = 1'b1;
        @(negedge clk);
        chk("drain consumed", bus0.out_valid, 0);
        wait_sweep0(busy_n, done_seen, ov_seen);
        chk("sweep2 done seen", done_seen, 1);
        chk("sweep2 tt", sweep_tt, exp_tt);
        chk("sweep2 err", sweep_err, 0);
        chk("sweep2 op_count", op_count, 11);

        // reset during RUN at k=10
        @(negedge clk);
        sweep_start = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0;
        repeat (11) @(negedge clk);
        chk("midrun busy", sweep_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst busy", sweep_busy, 0);
        chk("rst tt", sweep_tt, 0);
        chk("rst err", sweep_err, 0);
        chk("rst op_count", op_count, 0);
        chk("rst out_valid", bus0.out_valid, 0);
        chk("rst done", sweep_done, 0);
        rst = 1'b0;
        sweep_start = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0;
        wait_sweep0(busy_n, done_seen, ov_seen);
        chk("sweep3 done seen", done_seen, 1);
        chk("sweep3 busy cycles", busy_n, 33);
        chk("sweep3 tt", sweep_tt, exp_tt);

        // reset with a pending result discards it
        @(negedge clk);
        bus0.out_ready = 1'b0; bus0.in_valid = 1'b1; bus0.in_a = 8'hFF; bus0.in_op = 3'd7;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        chk("pending before rst", bus0.out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("pending discarded", bus0.out_valid, 0);
        chk("pending out_y cleared", bus0.out_y, 0);
        chk("pending op_count", op_count, 0);
        bus0.out_ready = 1'b1;

        // random stream against a queue model
        model_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bus0.in_valid  = ($urandom_range(0, 3) != 0);
            bus0.out_ready = ($urandom_range(0, 2) != 0);
            bus0.in_a      = 8'($urandom);
            bus0.in_b      = 8'($urandom);
            bus0.in_op     = 3'($urandom_range(0, 7));
            #1;
            exp_ready = (mq.size() == 0) || bus0.out_ready;
            chk("rnd in_ready", bus0.in_ready, exp_ready);
            chk("rnd out_valid", bus0.out_valid, mq.size() != 0);
            if (mq.size() != 0 && bus0.out_ready) begin
                r = mq.pop_front();
                chk("rnd out_y", bus0.out_y, r.y);
                chk("rnd out_op", bus0.out_op, r.op);
            end
            if (bus0.in_valid && exp_ready) begin
                mq.push_back('{bus0.in_op, ref_op(int'(bus0.in_op), bus0.in_a, bus0.in_b)});
                model_cnt++;
            end
        end
        @(negedge clk);
        bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
        chk("rnd op_count", op_count, model_cnt % 65536);

        // WIDTH=1, CNT_W=4: counter wrap and sweep
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            bus1.in_valid = 1'b1; bus1.in_a = 1'b1; bus1.in_op = 3'(i % 8);
        end
        @(negedge clk);
        bus1.in_valid = 1'b0;
        chk("w1 op_count wrap", op_count2, 1);
        sweep_start2 = 1'b1;
        @(negedge clk);
        sweep_start2 = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 200 && !done_seen; c++) begin
            @(negedge clk);
            if (sweep_done2) done_seen = 1;
        end
        chk("w1 sweep done seen", done_seen, 1);
        chk("w1 sweep tt", sweep_tt2, exp_tt);
        chk("w1 sweep err", sweep_err2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
